// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one shared memory port.
// Round-robin grant, one outstanding transaction, with a response timeout.
module mem_arbiter #(
    parameter int RegBits       = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               if_req_i,
    input  logic [RegBits-1:0] if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [RegBits-1:0] if_rdata_o,
    input  logic               dm_req_i,
    input  logic               dm_we_i,
    input  logic [RegBits-1:0] dm_addr_i,
    input  logic [RegBits-1:0] dm_wdata_i,
    output logic               dm_gnt_o,
    output logic               dm_rvalid_o,
    output logic [RegBits-1:0] dm_rdata_o,
    output logic               err_o,
    output logic               busy_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [RegBits-1:0] mem_addr_o,
    output logic [RegBits-1:0] mem_wdata_o,
    input  logic               mem_ready_i,
    input  logic               mem_rvalid_i,
    input  logic [RegBits-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [7:0] TmoLast = 8'(TimeoutCycles - 1);

    state_e             state_q, state_d;
    logic               last_dm_q, last_dm_d;
    logic               we_q, we_d;
    logic [RegBits-1:0] addr_q, addr_d;
    logic [RegBits-1:0] wdata_q, wdata_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               dm_rvalid_q, dm_rvalid_d;
    logic               err_q, err_d;
    logic [RegBits-1:0] if_rdata_q, if_rdata_d;
    logic [RegBits-1:0] dm_rdata_q, dm_rdata_d;

    logic any_req_s, pick_dm_s, grant_s, rsp_s, tmo_s, done_s;

    // Arbitration and end-of-transaction decode; last_dm_q doubles as the current owner
    always_comb begin
        any_req_s = if_req_i | dm_req_i;
        if (if_req_i && dm_req_i) begin
            pick_dm_s = ~last_dm_q;
        end else begin
            pick_dm_s = dm_req_i;
        end
        grant_s = rst_i && (state_q == ST_IDLE) && any_req_s;
        rsp_s   = (state_q == ST_WAIT) && mem_rvalid_i;
        tmo_s   = (state_q == ST_WAIT) && !mem_rvalid_i && (cnt_q == TmoLast);
        done_s  = rsp_s | tmo_s;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) state_d = ST_REQ;
                else           state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_ready_i) state_d = ST_WAIT;
                else             state_d = ST_REQ;
            end
            ST_WAIT: begin
                if (done_s) state_d = ST_IDLE;
                else        state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        if_gnt_o    = grant_s & ~pick_dm_s;
        dm_gnt_o    = grant_s & pick_dm_s;
        mem_req_o   = (state_q == ST_REQ);
        busy_o      = (state_q != ST_IDLE);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if_rvalid_o = if_rvalid_q;
        if_rdata_o  = if_rdata_q;
        dm_rvalid_o = dm_rvalid_q;
        dm_rdata_o  = dm_rdata_q;
        err_o       = err_q;
    end

    // Datapath next values: request capture, timeout counter, response staging
    always_comb begin
        if (grant_s) begin
            last_dm_d = pick_dm_s;
            we_d      = pick_dm_s & dm_we_i;
            addr_d    = pick_dm_s ? dm_addr_i : if_addr_i;
            wdata_d   = pick_dm_s ? dm_wdata_i : '0;
        end else begin
            last_dm_d = last_dm_q;
            we_d      = we_q;
            addr_d    = addr_q;
            wdata_d   = wdata_q;
        end

        if (state_q == ST_REQ && mem_ready_i) begin
            cnt_d = 8'd0;
        end else if (state_q == ST_WAIT && !done_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if_rvalid_d = done_s & ~last_dm_q;
        dm_rvalid_d = done_s & last_dm_q;
        err_d       = tmo_s;

        if (if_rvalid_d) begin
            if_rdata_d = tmo_s ? '0 : mem_rdata_i;
        end else begin
            if_rdata_d = if_rdata_q;
        end
        // Write acknowledges return zero data
        if (dm_rvalid_d) begin
            dm_rdata_d = (tmo_s || we_q) ? '0 : mem_rdata_i;
        end else begin
            dm_rdata_d = dm_rdata_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_dm_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 8'd0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            last_dm_q   <= last_dm_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         if_req_i, if_gnt_o, if_rvalid_o;
    logic [W-1:0] if_addr_i, if_rdata_o;
    logic         dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [W-1:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic         err_o, busy_o, mem_req_o, mem_we_o;
    logic [W-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic         mem_ready_i, mem_rvalid_i;

    int tests = 0;
    int fails = 0;

    // model state: last served port (1 = data) and held rdata per port
    bit           last_dm;
    logic [W-1:0] if_hold, dm_hold;

    mem_arbiter #(.RegBits(W), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o), .err_o(err_o), .busy_o(busy_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o,
                                err_o, busy_o, mem_req_o, mem_we_o}), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
        chk({tag, "_dm_rdata"}, dm_rdata_o, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    endtask

    // One transaction from the IDLE cycle to the response cycle.
    // rvd = WAIT cycle index carrying mem_rvalid; rvd >= TO means no response.
    task automatic run_txn(input bit ifr, input bit dmr, input bit dwe,
                           input logic [W-1:0] ia, input logic [W-1:0] da,
                           input logic [W-1:0] dwd, input logic [W-1:0] mrd,
                           input int rdy, input int rvd);
        bit           own_dm;
        bit           exp_we;
        bit           timed_out;
        logic [W-1:0] exp_addr, exp_wd, exp_rd;

        if_req_i = ifr; dm_req_i = dmr; if_addr_i = ia; dm_addr_i = da;
        dm_we_i = dwe; dm_wdata_i = dwd;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        own_dm = (ifr && dmr) ? !last_dm : dmr;
        #1;
        chk1("if_gnt", if_gnt_o, ifr && !own_dm);
        chk1("dm_gnt", dm_gnt_o, own_dm);
        chk1("idle_busy", busy_o, 1'b0);
        last_dm  = own_dm;
        exp_we   = own_dm && dwe;
        exp_addr = own_dm ? da : ia;
        exp_wd   = own_dm ? dwd : 32'd0;
        next_cycle();

        for (int k = 0; k <= rdy; k++) begin
            if_req_i = own_dm ? 1'($urandom_range(0, 1)) : 1'b0;
            dm_req_i = own_dm ? 1'b0 : 1'($urandom_range(0, 1));
            if_addr_i = $urandom; dm_addr_i = $urandom; dm_wdata_i = $urandom;
            dm_we_i = 1'($urandom_range(0, 1));
            mem_ready_i = (k == rdy);
            mem_rvalid_i = 1'($urandom_range(0, 1));
            #1;
            chk1("req_mem_req", mem_req_o, 1'b1);
            chk1("req_mem_we", mem_we_o, exp_we);
            chk("req_mem_addr", mem_addr_o, exp_addr);
            chk("req_mem_wdata", mem_wdata_o, exp_wd);
            chk("req_gnt_busy", 32'({if_gnt_o, dm_gnt_o, busy_o}), 32'd1);
            next_cycle();
        end

        timed_out = 1'b1;
        for (int k = 0; k < TO; k++) begin
            if_req_i = own_dm ? 1'($urandom_range(0, 1)) : 1'b0;
            dm_req_i = own_dm ? 1'b0 : 1'($urandom_range(0, 1));
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rvalid_i = (k == rvd);
            mem_rdata_i = (k == rvd) ? mrd : $urandom;
            #1;
            chk("wait_ctl", 32'({mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o,
                                 dm_rvalid_o, err_o, busy_o}), 32'd1);
            next_cycle();
            if (k == rvd) begin
                timed_out = 1'b0;
                break;
            end
        end

        if_req_i = 1'b0; dm_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        exp_rd = (timed_out || (own_dm && dwe)) ? 32'd0 : mrd;
        if (own_dm) dm_hold = exp_rd;
        else        if_hold = exp_rd;
        chk1("rsp_if_rvalid", if_rvalid_o, !own_dm);
        chk1("rsp_dm_rvalid", dm_rvalid_o, own_dm);
        chk("rsp_if_rdata", if_rdata_o, if_hold);
        chk("rsp_dm_rdata", dm_rdata_o, dm_hold);
        chk1("rsp_err", err_o, timed_out);
        chk1("rsp_busy", busy_o, 1'b0);
    endtask

    initial begin
        int r;
        bit ifr, dmr;

        rst_i = 1'b0;
        if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b1;
        if_addr_i = 32'h4; dm_addr_i = 32'h8; dm_wdata_i = 32'h1;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5;
        last_dm = 1'b0; if_hold = 32'd0; dm_hold = 32'd0;
        repeat (2) @(negedge clk_i);
        #1;
        chk_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // contention right after reset: data, fetch, data
        run_txn(1'b1, 1'b1, 1'b0, 32'h20, 32'h40, 32'h0, 32'hA1, 0, 0);
        run_txn(1'b1, 1'b1, 1'b0, 32'h24, 32'h44, 32'h0, 32'hA2, 0, 0);
        run_txn(1'b1, 1'b1, 1'b0, 32'h28, 32'h48, 32'h0, 32'hA3, 0, 0);
        // fetch only, minimum latency
        run_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h00500093, 0, 0);
        // data write with ready delayed 4 cycles
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 32'h12345678, 4, 2);
        // timeout, then idle afterwards
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 32'h55AA55AA, 1, 100);
        next_cycle();
        #1;
        chk("post_tmo_idle", 32'({busy_o, err_o, if_rvalid_o, dm_rvalid_o}), 32'd0);
        // response on the timeout cycle wins
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h204, 32'h0, 32'hCAFEF00D, 0, TO - 1);

        // reset during WAIT, then a stray mem_rvalid
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h300;
        next_cycle();
        if_req_i = 1'b0; mem_ready_i = 1'b1;
        next_cycle();
        mem_ready_i = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        chk_zero("rst_wait");
        next_cycle();
        #1;
        chk_zero("rst_hold");
        rst_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        next_cycle();
        mem_rvalid_i = 1'b0;
        #1;
        chk_zero("stray_rvalid");
        last_dm = 1'b0; if_hold = 32'd0; dm_hold = 32'd0;
        @(negedge clk_i);
        run_txn(1'b1, 1'b1, 1'b0, 32'h34, 32'h54, 32'h0, 32'h77, 1, 3);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(1, 3);
            ifr = r[0];
            dmr = r[1];
            run_txn(ifr, dmr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 19));
            if ($urandom_range(0, 3) == 0) begin
                next_cycle();
                #1;
                chk("gap_idle", 32'({busy_o, if_rvalid_o, dm_rvalid_o, err_o}), 32'd0);
                @(negedge clk_i);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
